// File: rtl/abs_peak_win.sv
// Windowed peak detector: tracks max magnitude and its first index over WIN accepted samples.
// Optional window sum output enabled by defining ABS_PEAK_WIN_SUM_EN.
module abs_peak_win #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned WIN    = 64,
    parameter int unsigned IDXW   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in,
    input  logic              win_clr,
    input  logic [DWIDTH-1:0] thr,
    output logic              out_valid,
    output logic [DWIDTH-1:0] peak,
    output logic [IDXW-1:0]   peak_idx,
    output logic              over_thr
`ifdef ABS_PEAK_WIN_SUM_EN
    ,
    output logic [DWIDTH+IDXW-1:0] sum
`endif
);

    localparam logic [IDXW-1:0] LAST = IDXW'(WIN - 1);

    typedef enum logic {EMPTY, ACC} state_t;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   cnt, cnt_nxt;
    logic [DWIDTH-1:0] run_max, max_nxt;
    logic [IDXW-1:0]   run_idx, idx_nxt;
    logic              ov_nxt, ot_nxt;
    logic [DWIDTH-1:0] peak_nxt;
    logic [IDXW-1:0]   pidx_nxt;

    logic              fresh;
    logic [DWIDTH-1:0] base_max, cur_max;
    logic [IDXW-1:0]   base_idx, base_cnt, cur_idx;

`ifdef ABS_PEAK_WIN_SUM_EN
    logic [DWIDTH+IDXW-1:0] acc, acc_nxt, sum_nxt, cur_sum;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        max_nxt   = run_max;
        idx_nxt   = run_idx;
        ov_nxt    = 1'b0;
        peak_nxt  = peak;
        pidx_nxt  = peak_idx;
        ot_nxt    = over_thr;

        // A cleared or empty window behaves as max=0 at index 0, so the strict
        // compare below also covers the first sample of a window.
        fresh    = win_clr || (state == EMPTY);
        base_max = fresh ? '0 : run_max;
        base_idx = fresh ? '0 : run_idx;
        base_cnt = fresh ? '0 : cnt;
        cur_max  = (in > base_max) ? in : base_max;
        cur_idx  = (in > base_max) ? base_cnt : base_idx;
`ifdef ABS_PEAK_WIN_SUM_EN
        acc_nxt  = acc;
        sum_nxt  = sum;
        cur_sum  = (fresh ? '0 : acc) + {{IDXW{1'b0}}, in};
`endif

        if (in_valid) begin
            if (base_cnt == LAST) begin
                ov_nxt    = 1'b1;
                peak_nxt  = cur_max;
                pidx_nxt  = cur_idx;
                ot_nxt    = (cur_max >= thr);
                state_nxt = EMPTY;
                cnt_nxt   = '0;
                max_nxt   = '0;
                idx_nxt   = '0;
`ifdef ABS_PEAK_WIN_SUM_EN
                sum_nxt   = cur_sum;
                acc_nxt   = '0;
`endif
            end else begin
                state_nxt = ACC;
                cnt_nxt   = base_cnt + 1'b1;
                max_nxt   = cur_max;
                idx_nxt   = cur_idx;
`ifdef ABS_PEAK_WIN_SUM_EN
                acc_nxt   = cur_sum;
`endif
            end
        end else if (win_clr) begin
            state_nxt = EMPTY;
            cnt_nxt   = '0;
            max_nxt   = '0;
            idx_nxt   = '0;
`ifdef ABS_PEAK_WIN_SUM_EN
            acc_nxt   = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            cnt       <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            out_valid <= 1'b0;
            peak      <= '0;
            peak_idx  <= '0;
            over_thr  <= 1'b0;
`ifdef ABS_PEAK_WIN_SUM_EN
            acc       <= '0;
            sum       <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            run_max   <= max_nxt;
            run_idx   <= idx_nxt;
            out_valid <= ov_nxt;
            peak      <= peak_nxt;
            peak_idx  <= pidx_nxt;
            over_thr  <= ot_nxt;
`ifdef ABS_PEAK_WIN_SUM_EN
            acc       <= acc_nxt;
            sum       <= sum_nxt;
`endif
        end
    end

endmodule
